// File: rtl/pending_reg_enc_pkg.sv
// Shared constants, FSM state type and priority-encode helper for pending_reg_encoder.
package pending_reg_enc_pkg;

   localparam int N_REGS  = 32;
   localparam int IDX_W   = $clog2(N_REGS);
   localparam int XZR_IDX = 31;

   localparam logic [N_REGS-1:0] XZR_BIT = N_REGS'(1) << XZR_IDX;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [N_REGS-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = N_REGS - 1; i >= 0; i--) begin
         if (vec[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/pending_reg_encoder_rr_pick32.sv
// Combinational round-robin picker: first set bit at or above rrPtr, else the
// first set bit overall (wrap-around).
module rr_pick32
   import pending_reg_enc_pkg::*;
(
   input  logic [N_REGS-1:0] pending,
   input  logic [IDX_W-1:0]  rrPtr,
   output logic              found,
   output logic [IDX_W-1:0]  pickIdx
);

   logic [N_REGS-1:0] hi_mask;
   logic [N_REGS-1:0] masked;

   generate
      for (genvar gi = 0; gi < N_REGS; gi++) begin : g_mask
         assign hi_mask[gi] = (IDX_W'(gi) >= rrPtr);
      end
   endgenerate

   assign masked = pending & hi_mask;

   always_comb begin
      found   = |pending;
      pickIdx = (|masked) ? lowest_set(masked) : lowest_set(pending);
   end

endmodule

// File: rtl/pending_reg_encoder.sv
// Serialises pending register flags into one round-robin index per handshake.
// Optional macro ZERO_REG_MASK_EN: index 31 (XZR) is never accepted or emitted.
module pending_reg_encoder
   import pending_reg_enc_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [N_REGS-1:0] setReq,
   input  logic              flush,
   input  logic              outReady,
   output logic              outValid,
   output logic [IDX_W-1:0]  regOut,
   output logic [N_REGS-1:0] pending,
   output logic              busy
);

   state_t            state_q,   state_d;
   logic [N_REGS-1:0] pending_q, pending_d;
   logic [IDX_W-1:0]  reg_out_q, reg_out_d;
   logic [IDX_W-1:0]  rr_ptr_q,  rr_ptr_d;

   logic [N_REGS-1:0] set_eff;
   logic [N_REGS-1:0] pick_mask;
   logic              found;
   logic [IDX_W-1:0]  pick_idx;
   logic              load;

`ifdef ZERO_REG_MASK_EN
   assign set_eff = setReq & ~XZR_BIT;
`else
   assign set_eff = setReq;
`endif

   rr_pick32 u_pick (
      .pending (pending_q),
      .rrPtr   (rr_ptr_q),
      .found   (found),
      .pickIdx (pick_idx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         reg_out_q <= '0;
         rr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         reg_out_q <= reg_out_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   always_comb begin
      load      = found && ((state_q == IDLE) || outReady);
      pick_mask = load ? (N_REGS'(1) << pick_idx) : '0;
      state_d   = state_q;
      pending_d = (pending_q & ~pick_mask) | set_eff;
      reg_out_d = load ? pick_idx : reg_out_q;
      rr_ptr_d  = rr_ptr_q;
      if (load) begin
         rr_ptr_d = (pick_idx == IDX_W'(N_REGS - 1)) ? '0 : pick_idx + IDX_W'(1);
      end

      case (state_q)
         IDLE:    if (found) state_d = OFFER;
         OFFER:   if (outReady && !found) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Flush wins over both the handshake and any same-cycle setReq.
      if (flush) begin
         state_d   = IDLE;
         pending_d = '0;
         reg_out_d = '0;
         rr_ptr_d  = '0;
      end
   end

   always_comb begin
      outValid = (state_q == OFFER);
      regOut   = reg_out_q;
      pending  = pending_q;
      busy     = outValid | (|pending_q);
   end

endmodule
